tune_sequencer: RTL and testbench
=================================

TUNE_SEQUENCER -- requirements
Module: tune_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 50000, clock cycles per duration tick (1 ms at 50 MHz); legal range 2..65535.
REQ-002 Parameter GAP_TICKS, default 10, silent ticks inserted after every note; 0 means no gap.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to play the tune selected by tune_sel.
REQ-006 tune_sel  input  2  tune index 0..3, sampled only in the cycle start=1.
REQ-007 stop  input  1  abort request; silences output and returns to idle.
REQ-008 play  output  1  registered enable to the speaker stage; 1 only while a non-rest note sounds.
REQ-009 frequency  output  15  registered half-period count for the speaker stage; the speaker toggles every frequency+1 cycles.
REQ-010 busy  output  1  registered; 1 from the cycle after an accepted start until the done pulse.
REQ-011 done  output  1  registered single-cycle pulse when a tune ends naturally; never asserted on stop.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, NOTE, GAP and FINISH.
REQ-013 IDLE: play=0, busy=0, and the FSM waits for start.
REQ-014 On start=1 (stop=0) in any state, the block SHALL latch tune_sel, clear note index to 0, and enter LOAD; start while busy preempts the current tune.
REQ-015 LOAD SHALL last exactly one cycle, issuing the ROM read at address {tune, index}; the entry is available in the following cycle.
REQ-016 A ROM entry SHALL be {half_period[14:0], duration[7:0], last[0]}; half_period 0 denotes a rest.
REQ-017 On entering NOTE: frequency <= half_period; play <= 1 if half_period != 0, else play <= 0; tick prescaler and tick counter cleared.
REQ-018 First note timing: start sampled at edge k gives busy=1 after edge k and play=1 (non-rest) after edge k+2.
REQ-019 NOTE SHALL last exactly max(duration,1) x TICK_DIV cycles; duration 0 is treated as 1.
REQ-020 frequency SHALL stay constant for the whole of NOTE and GAP.
REQ-021 From NOTE the FSM SHALL enter GAP with play=0; GAP SHALL last GAP_TICKS x TICK_DIV cycles and is skipped when GAP_TICKS=0.
REQ-022 After GAP: if last=0 and index!=15, the index SHALL increment and the FSM SHALL re-enter LOAD; otherwise the FSM SHALL enter FINISH.
REQ-023 Index 15 SHALL be treated as last regardless of its flag; the index never wraps.
REQ-024 FINISH SHALL last one cycle with done=1, then return to IDLE with busy=0 and frequency=0.
REQ-025 stop=1 SHALL force IDLE on the next edge: play=0, frequency=0, busy=0, done=0. stop wins over a simultaneous start.
REQ-026 start asserted in the same cycle as FINISH SHALL restart the tune (LOAD) and suppress done.
REQ-027 The prescaler SHALL be 16 bits and the tick counter 8 bits; no counter may overflow in any legal configuration.

Reset
REQ-028 While rst_n=0: state=IDLE; play=0, frequency=0, busy=0, done=0; index, prescaler and tick counters are 0.
REQ-029 Reset SHALL take effect immediately and asynchronously, including mid-note; the first start after reset release is honoured normally.

Structure
REQ-030 A shared package sound_pkg SHALL hold the note entry typedef, the FSM state enum, the tune IDs (TUNE_START, TUNE_CHOMP, TUNE_DEATH, TUNE_FRUIT) and the note half-period constants (for example C5=47778 is out of range, so octaves are chosen so that every value is <= 32767).
REQ-031 The ROM SHALL be a separate sub-module tune_rom: 64 x 24-bit, synchronous read, 6-bit address.
REQ-032 tune_sequencer SHALL drive the speaker stage play/frequency directly with no extra glue logic.

Verification (TICK_DIV=4, GAP_TICKS=1, test ROM)
REQ-033 Tune 0 = {100,2,0},{0,1,0},{200,1,1}; pulse start -> play=1 with freq=100 for 8 cycles, 4 low, 4 rest-low, 4 low, freq=200 for 4, 4 low, done pulse, then busy=0.
REQ-034 Entry with duration=0 -> NOTE lasts 4 cycles.
REQ-035 Tune with no last flag in 16 entries -> exactly 16 notes play, then done; index does not wrap.
REQ-036 start with tune 1 during tune 0 note 2 -> after 1 LOAD cycle, tune 1 note 0 plays; no done for tune 0.
REQ-037 stop and start in the same cycle mid-note -> next cycle IDLE with play=0, busy=0, no done; rst_n low mid-note -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types and constants for the tune sequencer: note entry layout, FSM states,
// tune IDs, half-period constants and the tune table contents.
package sound_pkg;

  typedef struct packed {
    logic [14:0] half_period;
    logic [7:0]  duration;
    logic        last;
  } note_t;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StNote   = 3'd2,
    StGap    = 3'd3,
    StFinish = 3'd4
  } seq_state_e;

  localparam logic [1:0] TUNE_START = 2'd0;
  localparam logic [1:0] TUNE_CHOMP = 2'd1;
  localparam logic [1:0] TUNE_DEATH = 2'd2;
  localparam logic [1:0] TUNE_FRUIT = 2'd3;

  // Half-period counts at 50 MHz; octaves picked so every value fits in 15 bits.
  localparam logic [14:0] NOTE_REST = 15'd0;
  localparam logic [14:0] NOTE_A5   = 15'd28408;
  localparam logic [14:0] NOTE_C6   = 15'd23888;
  localparam logic [14:0] NOTE_E6   = 15'd18960;
  localparam logic [14:0] NOTE_G6   = 15'd15942;
  localparam logic [14:0] NOTE_C7   = 15'd11943;

  function automatic note_t rom_entry(input logic [5:0] addr);
    note_t e;
    e = '0;
    case (addr[5:4])
      TUNE_START: begin
        case (addr[3:0])
          4'd0:    e = '{15'd100, 8'd2, 1'b0};
          4'd1:    e = '{NOTE_REST, 8'd1, 1'b0};
          4'd2:    e = '{15'd200, 8'd1, 1'b1};
          default: e = '0;
        endcase
      end
      TUNE_CHOMP: begin
        case (addr[3:0])
          4'd0:    e = '{NOTE_C6, 8'd1, 1'b0};
          4'd1:    e = '{NOTE_E6, 8'd1, 1'b1};
          default: e = '0;
        endcase
      end
      TUNE_DEATH: begin
        // Zero duration is played as one tick.
        if (addr[3:0] == 4'd0) e = '{NOTE_G6, 8'd0, 1'b1};
      end
      default: begin
        // No last flag anywhere: index 15 terminates the tune.
        e = '{15'd1000 + {11'd0, addr[3:0]}, 8'd1, 1'b0};
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/tune_rom.sv
// 64 x 24-bit synchronous-read tune table, addressed by {tune, note index}.
module tune_rom
  import sound_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_en,
  input  logic [5:0]  i_addr,
  output logic [23:0] o_data
);

  always_ff @(posedge i_clk) begin
    if (i_en) o_data <= rom_entry(i_addr);
  end

endmodule

// File: rtl/tune_sequencer.sv
// Steps through a selected tune in the ROM, driving the speaker stage with a
// half-period count and enable per note, with an optional silent gap between notes.
module tune_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned GAP_TICKS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  tune_sel,
  input  logic        stop,
  output logic        play,
  output logic [14:0] frequency,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);
  localparam logic [7:0]  GAP_MAX   = 8'(GAP_TICKS - 1);
  localparam logic        GAP_EN    = (GAP_TICKS != 0);

  seq_state_e  r_state;
  logic [1:0]  r_tune;
  logic [3:0]  r_idx;
  logic        r_fresh;
  logic [15:0] r_presc;
  logic [7:0]  r_ticks;
  logic [7:0]  r_dur_m1;
  logic        r_last;

  logic [23:0] w_rom_data;
  note_t       w_entry;
  logic        w_tick_end;
  logic        w_note_end;
  logic        w_gap_end;
  logic        w_seq_end;

  tune_rom u_rom (
    .i_clk  (clk),
    .i_en   (r_state == StLoad),
    .i_addr ({r_tune, r_idx}),
    .o_data (w_rom_data)
  );

  assign w_entry    = note_t'(w_rom_data);
  assign w_tick_end = (r_presc == PRESC_MAX);
  assign w_note_end = (r_state == StNote) && !r_fresh && w_tick_end && (r_ticks == r_dur_m1);
  assign w_gap_end  = (r_state == StGap) && w_tick_end && (r_ticks == GAP_MAX);
  assign w_seq_end  = w_gap_end || (!GAP_EN && w_note_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_tune    <= 2'd0;
      r_idx     <= 4'd0;
      r_fresh   <= 1'b0;
      r_presc   <= 16'd0;
      r_ticks   <= 8'd0;
      r_dur_m1  <= 8'd0;
      r_last    <= 1'b0;
      play      <= 1'b0;
      frequency <= 15'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (stop) begin
      r_state   <= StIdle;
      r_fresh   <= 1'b0;
      r_presc   <= 16'd0;
      r_ticks   <= 8'd0;
      play      <= 1'b0;
      frequency <= 15'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (start) begin
      r_state <= StLoad;
      r_tune  <= tune_sel;
      r_idx   <= 4'd0;
      r_fresh <= 1'b0;
      play    <= 1'b0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        StIdle: ;
        StLoad: begin
          r_state <= StNote;
          r_fresh <= 1'b1;
        end
        StNote: begin
          // First NOTE cycle is where the ROM word becomes visible; timing starts after it.
          if (r_fresh) begin
            r_fresh   <= 1'b0;
            frequency <= w_entry.half_period;
            play      <= (w_entry.half_period != 15'd0);
            r_dur_m1  <= (w_entry.duration == 8'd0) ? 8'd0 : w_entry.duration - 8'd1;
            r_last    <= w_entry.last;
            r_presc   <= 16'd0;
            r_ticks   <= 8'd0;
          end else if (w_tick_end) begin
            r_presc <= 16'd0;
            if (w_note_end) begin
              play    <= 1'b0;
              r_ticks <= 8'd0;
              r_state <= StGap;
            end else begin
              r_ticks <= r_ticks + 8'd1;
            end
          end else begin
            r_presc <= r_presc + 16'd1;
          end
        end
        StGap: begin
          if (w_tick_end) begin
            r_presc <= 16'd0;
            r_ticks <= r_ticks + 8'd1;
          end else begin
            r_presc <= r_presc + 16'd1;
          end
        end
        StFinish: begin
          r_state   <= StIdle;
          busy      <= 1'b0;
          frequency <= 15'd0;
        end
        default: r_state <= StIdle;
      endcase

      if (w_seq_end) begin
        r_ticks <= 8'd0;
        if (r_last || (r_idx == 4'hF)) begin
          r_state <= StFinish;
          done    <= 1'b1;
        end else begin
          r_idx   <= r_idx + 4'd1;
          r_state <= StLoad;
        end
      end
    end
  end

endmodule

// File: tb/tb_tune_sequencer.sv
// Directed bench for tune_sequencer with TICK_DIV=4, GAP_TICKS=1 against the built-in tune table.
module tb_tune_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  tune_sel;
  logic        stop;
  logic        play;
  logic [14:0] frequency;
  logic        busy;
  logic        done;

  int n_checks;
  int n_fail;

  localparam logic [14:0] F_C6 = 15'd23888;
  localparam logic [14:0] F_E6 = 15'd18960;
  localparam logic [14:0] F_G6 = 15'd15942;

  tune_sequencer #(
    .TICK_DIV  (4),
    .GAP_TICKS (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tune_sel  (tune_sel),
    .stop      (stop),
    .play      (play),
    .frequency (frequency),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic p, input logic [14:0] f, input logic b,
                         input logic d);
    chk({tag, ".play"}, 32'(play), 32'(p));
    chk({tag, ".freq"}, 32'(frequency), 32'(f));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_n(input int n, input string tag, input logic p, input logic [14:0] f,
                          input logic b, input logic d);
    for (int i = 0; i < n; i++) begin
      step();
      chk_out(tag, p, f, b, d);
    end
  endtask

  // Start is sampled on the edge inside this task; returns 1 ns after that edge.
  task automatic go(input logic [1:0] sel);
    start    = 1'b1;
    tune_sel = sel;
    step();
    start    = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    tune_sel = 2'd0;

    #3;
    chk_out("reset", 1'b0, 15'd0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    expect_n(2, "idle_after_reset", 1'b0, 15'd0, 1'b0, 1'b0);

    // Tune 0: note, rest, last note
    go(2'd0);
    chk_out("t0_load", 1'b0, 15'd0, 1'b1, 1'b0);
    expect_n(1, "t0_fetch",  1'b0, 15'd0,   1'b1, 1'b0);
    expect_n(8, "t0_n0",     1'b1, 15'd100, 1'b1, 1'b0);
    expect_n(4, "t0_g0",     1'b0, 15'd100, 1'b1, 1'b0);
    expect_n(2, "t0_l1",     1'b0, 15'd100, 1'b1, 1'b0);
    expect_n(4, "t0_rest",   1'b0, 15'd0,   1'b1, 1'b0);
    expect_n(4, "t0_g1",     1'b0, 15'd0,   1'b1, 1'b0);
    expect_n(2, "t0_l2",     1'b0, 15'd0,   1'b1, 1'b0);
    expect_n(4, "t0_n2",     1'b1, 15'd200, 1'b1, 1'b0);
    expect_n(4, "t0_g2",     1'b0, 15'd200, 1'b1, 1'b0);
    expect_n(1, "t0_finish", 1'b0, 15'd200, 1'b1, 1'b1);
    expect_n(3, "t0_idle",   1'b0, 15'd0,   1'b0, 1'b0);

    // Tune 2: zero duration plays one tick
    go(2'd2);
    chk_out("t2_load", 1'b0, 15'd0, 1'b1, 1'b0);
    expect_n(1, "t2_fetch",  1'b0, 15'd0, 1'b1, 1'b0);
    expect_n(4, "t2_n0",     1'b1, F_G6,  1'b1, 1'b0);
    expect_n(4, "t2_g0",     1'b0, F_G6,  1'b1, 1'b0);
    expect_n(1, "t2_finish", 1'b0, F_G6,  1'b1, 1'b1);
    expect_n(1, "t2_idle",   1'b0, 15'd0, 1'b0, 1'b0);

    // Tune 3: sixteen notes, no last flag, ends at index 15
    go(2'd3);
    chk_out("t3_load", 1'b0, 15'd0, 1'b1, 1'b0);
    expect_n(1, "t3_fetch", 1'b0, 15'd0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      expect_n(4, "t3_note", 1'b1, 15'(1000 + i), 1'b1, 1'b0);
      expect_n(4, "t3_gap",  1'b0, 15'(1000 + i), 1'b1, 1'b0);
      if (i < 15) expect_n(2, "t3_load", 1'b0, 15'(1000 + i), 1'b1, 1'b0);
    end
    expect_n(1, "t3_finish", 1'b0, 15'd1015, 1'b1, 1'b1);
    expect_n(2, "t3_idle",   1'b0, 15'd0,    1'b0, 1'b0);

    // Preempt tune 0 during its note 2 with tune 1
    go(2'd0);
    expect_n(1, "pre_fetch", 1'b0, 15'd0,   1'b1, 1'b0);
    expect_n(8, "pre_n0",    1'b1, 15'd100, 1'b1, 1'b0);
    expect_n(6, "pre_g0",    1'b0, 15'd100, 1'b1, 1'b0);
    expect_n(8, "pre_rest",  1'b0, 15'd0,   1'b1, 1'b0);
    expect_n(2, "pre_l2",    1'b0, 15'd0,   1'b1, 1'b0);
    expect_n(2, "pre_n2",    1'b1, 15'd200, 1'b1, 1'b0);
    go(2'd1);
    chk_out("pre_load", 1'b0, 15'd200, 1'b1, 1'b0);
    expect_n(1, "pre_fetch1", 1'b0, 15'd200, 1'b1, 1'b0);
    expect_n(4, "t1_n0",      1'b1, F_C6,    1'b1, 1'b0);
    expect_n(6, "t1_g0",      1'b0, F_C6,    1'b1, 1'b0);
    expect_n(4, "t1_n1",      1'b1, F_E6,    1'b1, 1'b0);
    expect_n(4, "t1_g1",      1'b0, F_E6,    1'b1, 1'b0);
    expect_n(1, "t1_finish",  1'b0, F_E6,    1'b1, 1'b1);
    expect_n(1, "t1_idle",    1'b0, 15'd0,   1'b0, 1'b0);

    // Stop and start together mid-note: stop wins
    go(2'd1);
    expect_n(1, "ss_fetch", 1'b0, 15'd0, 1'b1, 1'b0);
    expect_n(2, "ss_note",  1'b1, F_C6,  1'b1, 1'b0);
    stop     = 1'b1;
    start    = 1'b1;
    tune_sel = 2'd0;
    step();
    stop  = 1'b0;
    start = 1'b0;
    chk_out("ss_stopped", 1'b0, 15'd0, 1'b0, 1'b0);
    expect_n(6, "ss_idle", 1'b0, 15'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-note
    go(2'd1);
    expect_n(1, "ar_fetch", 1'b0, 15'd0, 1'b1, 1'b0);
    expect_n(2, "ar_note",  1'b1, F_C6,  1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("ar_async", 1'b0, 15'd0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    chk_out("ar_release", 1'b0, 15'd0, 1'b0, 1'b0);

    // First start after reset, then restart on the cycle the tune would finish
    go(2'd2);
    chk_out("rs_load", 1'b0, 15'd0, 1'b1, 1'b0);
    expect_n(1, "rs_fetch", 1'b0, 15'd0, 1'b1, 1'b0);
    expect_n(4, "rs_note",  1'b1, F_G6,  1'b1, 1'b0);
    expect_n(4, "rs_gap",   1'b0, F_G6,  1'b1, 1'b0);
    go(2'd1);
    chk_out("rs_restart", 1'b0, F_G6, 1'b1, 1'b0);
    expect_n(1, "rs_fetch1", 1'b0, F_G6, 1'b1, 1'b0);
    expect_n(4, "rs_t1_n0",  1'b1, F_C6, 1'b1, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_out("rs_stop", 1'b0, 15'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
